multi_channel_pwm_generator: RTL and testbench

//  N-channel programmable square/PWM generator; successor of the single-channel fixed-table square generator.

---
 rtl/multi_channel_pwm_generator.sv | 137 +++++++++++++
 tb/tb_multi_channel_pwm_generator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_pwm_generator.sv
// N-channel programmable PWM generator with double-buffered period/high settings.
// Optional SQW_GEN_SYNC_EN adds a sync_i input for phase-aligned restart of all channels.
module multi_channel_pwm_generator #(
  parameter int               CH_NUM     = 4,
  parameter int               CNT_W      = 32,
  parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(50_000_000),
  parameter logic [CNT_W-1:0] DEF_HIGH   = CNT_W'(25_000_000),
  localparam int              CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [CH_NUM-1:0] ch_en_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_period_i,
  input  logic [CNT_W-1:0]  cfg_high_i,
  output logic [CH_NUM-1:0] wave_o,
  output logic [CH_NUM-1:0] wrap_o
`ifdef SQW_GEN_SYNC_EN
  ,
  input  logic              sync_i
`endif
);

  logic [CNT_W-1:0]  cnt_q        [CH_NUM];
  logic [CNT_W-1:0]  cnt_d        [CH_NUM];
  logic [CNT_W-1:0]  act_period_q [CH_NUM];
  logic [CNT_W-1:0]  act_period_d [CH_NUM];
  logic [CNT_W-1:0]  act_high_q   [CH_NUM];
  logic [CNT_W-1:0]  act_high_d   [CH_NUM];
  logic [CNT_W-1:0]  pend_period_q[CH_NUM];
  logic [CNT_W-1:0]  pend_period_d[CH_NUM];
  logic [CNT_W-1:0]  pend_high_q  [CH_NUM];
  logic [CNT_W-1:0]  pend_high_d  [CH_NUM];
  logic [CH_NUM-1:0] pend_q;
  logic [CH_NUM-1:0] pend_d;
  logic [CH_NUM-1:0] wave_q;
  logic [CH_NUM-1:0] wave_d;
  logic [CH_NUM-1:0] wrap_q;
  logic [CH_NUM-1:0] wrap_d;

  logic              cfgReady;
  logic              cfgFire;
  logic              syncReq;
  logic [CH_NUM-1:0] takePend;

`ifdef SQW_GEN_SYNC_EN
  assign syncReq = sync_i;
`else
  assign syncReq = 1'b0;
`endif

  // Out-of-range channel indices match no channel, so they are never ready.
  always_comb begin
    cfgReady = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (cfg_ch_i == CH_W'(i)) begin
        cfgReady = !pend_q[i];
      end
    end
  end

  assign cfgFire     = cfg_valid_i && cfgReady;
  assign cfg_ready_o = cfgReady;

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      cnt_d[i]         = cnt_q[i];
      act_period_d[i]  = act_period_q[i];
      act_high_d[i]    = act_high_q[i];
      pend_period_d[i] = pend_period_q[i];
      pend_high_d[i]   = pend_high_q[i];
      pend_d[i]        = pend_q[i];
      wave_d[i]        = 1'b0;
      wrap_d[i]        = 1'b0;
      takePend[i]      = 1'b0;

      if (cfgFire && (cfg_ch_i == CH_W'(i))) begin
        pend_period_d[i] = cfg_period_i;
        pend_high_d[i]   = cfg_high_i;
        pend_d[i]        = 1'b1;
      end

      // Idle, restarting or invalid-period channels sit at zero and absorb pending settings.
      if (!ch_en_i[i] || syncReq || (act_period_q[i] < CNT_W'(2))) begin
        cnt_d[i]    = '0;
        takePend[i] = 1'b1;
      end else if (cnt_q[i] == act_period_q[i] - CNT_W'(1)) begin
        cnt_d[i]    = '0;
        wrap_d[i]   = 1'b1;
        wave_d[i]   = (cnt_q[i] < act_high_q[i]);
        takePend[i] = 1'b1;
      end else begin
        cnt_d[i]    = cnt_q[i] + CNT_W'(1);
        wave_d[i]   = (cnt_q[i] < act_high_q[i]);
      end

      // A write can only land while pend_q is clear, so it never collides with this swap.
      if (takePend[i] && pend_q[i]) begin
        act_period_d[i] = pend_period_q[i];
        act_high_d[i]   = pend_high_q[i];
        pend_d[i]       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < CH_NUM; i++) begin
        cnt_q[i]         <= '0;
        act_period_q[i]  <= DEF_PERIOD;
        act_high_q[i]    <= DEF_HIGH;
        pend_period_q[i] <= '0;
        pend_high_q[i]   <= '0;
      end
      pend_q <= '0;
      wave_q <= '0;
      wrap_q <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        cnt_q[i]         <= cnt_d[i];
        act_period_q[i]  <= act_period_d[i];
        act_high_q[i]    <= act_high_d[i];
        pend_period_q[i] <= pend_period_d[i];
        pend_high_q[i]   <= pend_high_d[i];
      end
      pend_q <= pend_d;
      wave_q <= wave_d;
      wrap_q <= wrap_d;
    end
  end

  assign wave_o = wave_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_multi_channel_pwm_generator.sv
// Directed bench for multi_channel_pwm_generator: waveform-shape table plus hand-written
// config/enable/reset sequences; the SQW_GEN_SYNC_EN sequence runs only when that macro is defined.
module tb_multi_channel_pwm_generator;

  localparam int CH_NUM = 3;
  localparam int CNT_W  = 32;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rstN;
  logic [CH_NUM-1:0] chEn;
  logic              cfgValid;
  logic              cfgReady;
  logic [CH_W-1:0]   cfgCh;
  logic [CNT_W-1:0]  cfgPeriod;
  logic [CNT_W-1:0]  cfgHigh;
  logic [CH_NUM-1:0] wave;
  logic [CH_NUM-1:0] wrap;
`ifdef SQW_GEN_SYNC_EN
  logic              sync;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  multi_channel_pwm_generator #(
    .CH_NUM    (CH_NUM),
    .CNT_W     (CNT_W),
    .DEF_PERIOD(32'd10),
    .DEF_HIGH  (32'd5)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .ch_en_i     (chEn),
    .cfg_valid_i (cfgValid),
    .cfg_ready_o (cfgReady),
    .cfg_ch_i    (cfgCh),
    .cfg_period_i(cfgPeriod),
    .cfg_high_i  (cfgHigh),
    .wave_o      (wave),
    .wrap_o      (wrap)
`ifdef SQW_GEN_SYNC_EN
    ,
    .sync_i      (sync)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int period;
    int high;
    int window;
    int expFirst;
    int expHighs;
    int expWraps;
  } shapeVec_t;

  shapeVec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [CH_W-1:0] ch,
                               input logic [CNT_W-1:0] period, input logic [CNT_W-1:0] high);
    cfgValid  = valid;
    cfgCh     = ch;
    cfgPeriod = period;
    cfgHigh   = high;
  endtask

  initial begin
    int  highs;
    int  wraps;
    logic expWaveA [18];
    logic expWrapA [18];
    logic expRdyA  [18];

    vecs[0] = '{0, 10, 5, 20, 1, 10, 2};
    vecs[1] = '{1,  8, 2, 16, 1,  4, 2};
    vecs[2] = '{2,  8, 0, 16, 0,  0, 2};
    vecs[3] = '{2,  8, 8, 16, 1, 16, 2};
    vecs[4] = '{1,  1, 1, 10, 0,  0, 0};
    vecs[5] = '{0,  2, 1,  8, 1,  4, 4};
    vecs[6] = '{1,  5, 9, 10, 1, 10, 2};
    vecs[7] = '{2,  3, 2,  9, 1,  6, 3};

    expWaveA = '{0,0,0,0,1,1,0,0,0,0,0,0,1,1,1,0,0,0};
    expWrapA = '{0,0,0,1,0,0,0,0,0,0,0,1,0,0,0,0,0,1};
    expRdyA  = '{0,0,0,1,0,0,0,0,0,0,0,1,1,1,1,1,1,1};

    rstN = 1'b0;
    chEn = '0;
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0);
`ifdef SQW_GEN_SYNC_EN
    sync = 1'b0;
`endif
    tick();
    tick();
    checkOutput("reset wave", 32'(wave), 32'd0);
    checkOutput("reset wrap", 32'(wrap), 32'd0);
    checkOutput("reset ready", 32'(cfgReady), 32'd1);
    applyStimulus(1'b0, 2'd3, 32'd0, 32'd0);
    checkOutput("out-of-range ready", 32'(cfgReady), 32'd0);

    // Default 10/5 settings straight out of reset.
    rstN = 1'b1;
    chEn = 3'b001;
    for (int j = 1; j <= 20; j++) begin
      tick();
      checkOutput($sformatf("default wave j%0d", j), 32'(wave[0]), 32'(((j - 1) % 10) < 5));
      checkOutput($sformatf("default wrap j%0d", j), 32'(wrap[0]), 32'((j % 10) == 0));
    end

    for (int v = 0; v < 8; v++) begin
      chEn = '0;
      tick();
      applyStimulus(1'b1, CH_W'(vecs[v].ch), CNT_W'(vecs[v].period), CNT_W'(vecs[v].high));
      checkOutput($sformatf("vec%0d ready", v), 32'(cfgReady), 32'd1);
      tick();
      applyStimulus(1'b0, CH_W'(vecs[v].ch), 32'd0, 32'd0);
      tick();
      chEn[vecs[v].ch] = 1'b1;
      highs = 0;
      wraps = 0;
      for (int n = 1; n <= vecs[v].window; n++) begin
        tick();
        if (n == 1) checkOutput($sformatf("vec%0d first", v), 32'(wave[vecs[v].ch]), 32'(vecs[v].expFirst));
        highs += int'(wave[vecs[v].ch]);
        wraps += int'(wrap[vecs[v].ch]);
      end
      checkOutput($sformatf("vec%0d highs", v), 32'(highs), 32'(vecs[v].expHighs));
      checkOutput($sformatf("vec%0d wraps", v), 32'(wraps), 32'(vecs[v].expWraps));
    end

    // Mid-period write, stalled second write, and an interleaved write to another channel.
    rstN = 1'b0;
    chEn = '0;
    applyStimulus(1'b0, 2'd1, 32'd0, 32'd0);
    tick();
    rstN = 1'b1;
    chEn = 3'b010;
    for (int n = 1; n <= 3; n++) begin
      tick();
      checkOutput($sformatf("seqA wave n%0d", n), 32'(wave[1]), 32'd1);
    end
    applyStimulus(1'b1, 2'd1, 32'd8, 32'd2);
    checkOutput("seqA ready before write", 32'(cfgReady), 32'd1);
    tick();
    applyStimulus(1'b0, 2'd1, 32'd8, 32'd2);
    checkOutput("seqA wave n4", 32'(wave[1]), 32'd1);
    checkOutput("seqA ready pend", 32'(cfgReady), 32'd0);
    applyStimulus(1'b1, 2'd1, 32'd6, 32'd3);
    checkOutput("seqA second write stalled", 32'(cfgReady), 32'd0);
    tick();
    checkOutput("seqA wave n5", 32'(wave[1]), 32'd1);
    applyStimulus(1'b1, 2'd2, 32'd4, 32'd1);
    checkOutput("seqA ch2 ready", 32'(cfgReady), 32'd1);
    tick();
    checkOutput("seqA wave n6", 32'(wave[1]), 32'd0);
    applyStimulus(1'b1, 2'd1, 32'd6, 32'd3);
    for (int n = 7; n <= 24; n++) begin
      tick();
      checkOutput($sformatf("seqA wave n%0d", n), 32'(wave[1]), 32'(expWaveA[n - 7]));
      checkOutput($sformatf("seqA wrap n%0d", n), 32'(wrap[1]), 32'(expWrapA[n - 7]));
      checkOutput($sformatf("seqA ready n%0d", n), 32'(cfgReady), 32'(expRdyA[n - 7]));
      if (n == 11) applyStimulus(1'b0, 2'd1, 32'd6, 32'd3);
    end

    // ch2 settings landed while it was disabled.
    applyStimulus(1'b0, 2'd2, 32'd0, 32'd0);
    checkOutput("ch2 ready idle", 32'(cfgReady), 32'd1);
    chEn = 3'b110;
    for (int m = 1; m <= 8; m++) begin
      tick();
      checkOutput($sformatf("ch2 wave m%0d", m), 32'(wave[2]), 32'(((m - 1) % 4) < 1));
      checkOutput($sformatf("ch2 wrap m%0d", m), 32'(wrap[2]), 32'((m % 4) == 0));
    end

    // Drop ch1 mid-period, reprogram while disabled, then re-enable.
    chEn = 3'b100;
    tick();
    checkOutput("disable wave", 32'(wave[1]), 32'd0);
    checkOutput("disable wrap", 32'(wrap[1]), 32'd0);
    applyStimulus(1'b1, 2'd1, 32'd5, 32'd2);
    checkOutput("disabled ready", 32'(cfgReady), 32'd1);
    tick();
    applyStimulus(1'b0, 2'd1, 32'd5, 32'd2);
    checkOutput("disabled pend set", 32'(cfgReady), 32'd0);
    tick();
    checkOutput("disabled pend applied", 32'(cfgReady), 32'd1);
    chEn = 3'b110;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput($sformatf("reenable wave k%0d", k), 32'(wave[1]), 32'(((k - 1) % 5) < 2));
      checkOutput($sformatf("reenable wrap k%0d", k), 32'(wrap[1]), 32'((k % 5) == 0));
    end

    applyStimulus(1'b1, 2'd3, 32'd4, 32'd4);
    checkOutput("out-of-range write ready", 32'(cfgReady), 32'd0);
    tick();

    // Reset while a write is pending must fall back to the defaults.
    applyStimulus(1'b1, 2'd1, 32'd7, 32'd3);
    tick();
    applyStimulus(1'b0, 2'd1, 32'd7, 32'd3);
    checkOutput("pre-reset pend", 32'(cfgReady), 32'd0);
    rstN = 1'b0;
    chEn = 3'b010;
    tick();
    checkOutput("reset clears pend", 32'(cfgReady), 32'd1);
    checkOutput("reset wave ch1", 32'(wave[1]), 32'd0);
    rstN = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      tick();
      checkOutput($sformatf("discard wave j%0d", j), 32'(wave[1]), 32'(((j - 1) % 10) < 5));
      checkOutput($sformatf("discard wrap j%0d", j), 32'(wrap[1]), 32'((j % 10) == 0));
    end

`ifdef SQW_GEN_SYNC_EN
    rstN = 1'b0;
    chEn = '0;
    tick();
    rstN = 1'b1;
    applyStimulus(1'b1, 2'd0, 32'd6, 32'd3);
    tick();
    applyStimulus(1'b1, 2'd1, 32'd4, 32'd2);
    tick();
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0);
    tick();
    chEn = 3'b001;
    repeat (3) tick();
    chEn = 3'b011;
    repeat (2) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    checkOutput("sync wave", 32'(wave[1:0]), 32'd0);
    checkOutput("sync wrap", 32'(wrap[1:0]), 32'd0);
    for (int n = 1; n <= 12; n++) begin
      tick();
      checkOutput($sformatf("sync ch0 wave n%0d", n), 32'(wave[0]), 32'(((n - 1) % 6) < 3));
      checkOutput($sformatf("sync ch0 wrap n%0d", n), 32'(wrap[0]), 32'((n % 6) == 0));
      checkOutput($sformatf("sync ch1 wave n%0d", n), 32'(wave[1]), 32'(((n - 1) % 4) < 2));
      checkOutput($sformatf("sync ch1 wrap n%0d", n), 32'(wrap[1]), 32'((n % 4) == 0));
    end
    checkOutput("sync aligned wraps", 32'(wrap[1:0]), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
